ascii_lane_counter: RTL and testbench
=====================================

# ascii_lane_counter

Multi-lane decimal ASCII counter that feeds several parallel hash cores with consecutive candidate suffixes. It holds LANES counters. Lane l carries value base+l, and every lane advances by LANES per accepted batch, so the lanes jointly enumerate every integer exactly once. Output uses a valid/ready handshake, a sticky overflow flag stops enumeration, and a synchronous clear restarts the sweep without a full reset.

## Interface

Parameters:
- DIGITS, default 8: decimal digits per lane, 1..20.
- LANES, default 4: number of lanes and per-batch stride, 1..9.
- START, default 1: value of lane 0 after reset or clear. Constraint: START ≥ 0 and START+LANES-1 < 10^DIGITS (elaboration-time check).

Ports:
- clk, in, 1: clock.
- reset, in, 1: asynchronous, active-high reset.
- clear, in, 1: synchronous restart to START.
- ready, in, 1: consumer accepts the current batch.
- valid, out, 1: batch on ascii_digits is valid.
- ascii_digits, out, LANES*8*DIGITS: lane l occupies [l*8*DIGITS +: 8*DIGITS]. Within a lane, digit i occupies [8*i +: 8] and digit 0 is least significant. Characters are 0x30..0x39 only.
- enabled_digits, out, LANES*W with W=$clog2(1+DIGITS): lane l occupies [l*W +: W]. Value is the significant digit count, minimum 1.
- overflow, out, 1: sticky flag; the next advance would exceed 10^DIGITS-1.

## Operation

- State machine states:
  - LOAD: entered on reset or clear; valid=0.
  - RUN: valid=1.
  - DONE: valid=0, overflow=1.
- Transitions:
  - LOAD → RUN unconditionally on the next clk.
  - RUN → RUN on handshake (valid&&ready) when no lane carries out.
  - RUN → DONE on handshake when any lane would carry out of digit DIGITS-1.
  - DONE holds until clear or reset.
- Advance on handshake in RUN:
  - Each lane adds LANES in decimal. Digit 0 becomes d0+LANES; if the sum is ≥10, subtract 10 and carry 1.
  - Higher digits increment on carry-in, wrapping 9→0 and propagating the carry.
  - All lanes update in the same cycle.
- Overflow:
  - The carry-out of the top digit is evaluated combinationally for every lane before the update.
  - If any lane carries out, the whole advance is suppressed: digits hold the last batch, overflow is set, and the state moves to DONE.
  - The highest lane always overflows first, but all lanes are checked.
- enabled_digits: combinational from the registered digits. It is the index+1 of the most significant non-'0' digit, or 1 if all digits are '0'.
- clear has priority over a simultaneous handshake:
  - lane l reloads START+l;
  - overflow clears;
  - state moves to LOAD.
- ready while valid=0 has no effect.

## Timing

- Reset values, applied asynchronously with no clock edge required:
  - lane l = START+l as ASCII, zero-padded to DIGITS;
  - valid=0, overflow=0, state LOAD;
  - enabled_digits follows the digits.
- First valid=1 appears one clk after reset deassertion, or one clk after clear.
- Advance latency: a handshake at edge n makes the new batch visible after edge n.
- Throughput is one batch per cycle with ready held high.
- Holding ready=0 keeps valid=1 and all outputs stable.
- valid never drops in RUN without a handshake, clear or reset.
- Overflow rises in the same cycle valid falls: edge after the suppressed handshake.

## Test plan

1. Reset release, DIGITS=4, LANES=3, START=1 → lanes "0001","0002","0003"; enabled_digits 1,1,1; valid=0 for one cycle, then 1; overflow=0.
2. ready=0 for 10 cycles after valid → digits and valid unchanged throughout.
3. ready=1 continuously, same config → after 3 handshakes lanes read "0010","0011","0012" (lane 0 carries via 7+3); enabled_digits 2,2,2; no bubbles.
4. Overflow, DIGITS=2, LANES=3, START=1 → reach lanes "97","98","99"; the next handshake is suppressed: lanes hold 97/98/99, overflow=1, valid=0; further ready pulses change nothing.
5. clear asserted together with a handshake mid-run → lanes reload START+l, handshake ignored, valid=0 one cycle, overflow=0, then RUN resumes.
6. reset asserted between clock edges mid-run → all outputs take reset values immediately. Also check LANES=1, DIGITS=3 from START=98: the sequence is 098, 099, 100, with enabled_digits going 2, 2, 3.

Source files
------------

// File: rtl/ascii_lane_counter.sv
// Multi-lane decimal ASCII counter: lane l holds base+l, all lanes advance by LANES per
// accepted batch, with a sticky overflow stop and a synchronous clear back to START.
module ascii_lane_counter #(
    parameter int unsigned     DIGITS = 8,
    parameter int unsigned     LANES  = 4,
    parameter longint unsigned START  = 64'd1
) (
    input  logic                                   clk,
    input  logic                                   reset,
    input  logic                                   clear,
    input  logic                                   ready,
    output logic                                   valid,
    output logic [LANES*8*DIGITS-1:0]              ascii_digits,
    output logic [LANES*$clog2(1+DIGITS)-1:0]      enabled_digits,
    output logic                                   overflow
);

    localparam int unsigned W = $clog2(1 + DIGITS);

    localparam logic [1:0] LOAD = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    function automatic longint unsigned pow10(input int unsigned n);
        longint unsigned p;
        p = 64'd1;
        for (int unsigned k = 0; k < n; k++) p = p * 64'd10;
        return p;
    endfunction

    function automatic logic [3:0] start_digit(input int unsigned lane, input int unsigned idx);
        longint unsigned v;
        v = START + 64'(lane);
        for (int unsigned k = 0; k < idx; k++) v = v / 64'd10;
        return 4'(v % 64'd10);
    endfunction

    // With 20 digits every 64-bit START fits, so the range check only applies below that.
    if (DIGITS < 1 || DIGITS > 20 || LANES < 1 || LANES > 9 ||
        (DIGITS < 20 && (START + 64'(LANES) - 64'd1) >= pow10(DIGITS))) begin : g_param_check
        $error("ascii_lane_counter: DIGITS/LANES/START out of range");
    end

    logic [1:0]                          state;
    logic [LANES-1:0][DIGITS-1:0][3:0]   bcd;
    logic [LANES-1:0][DIGITS-1:0][3:0]   bcd_next;
    logic [LANES-1:0][DIGITS-1:0][3:0]   bcd_init;
    logic [LANES-1:0]                    lane_carry;
    logic                                any_carry;
    logic                                carry;
    logic [4:0]                          digit_sum;
    logic [W-1:0]                        digit_count;

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        for (genvar i = 0; i < DIGITS; i++) begin : g_digit
            assign bcd_init[l][i] = start_digit(l, i);
            assign ascii_digits[l*8*DIGITS + 8*i +: 8] = {4'h3, bcd[l][i]};
        end
    end

    // Digit 0 absorbs the whole stride; higher digits only ever see a carry of one.
    always_comb begin
        bcd_next   = bcd;
        lane_carry = '0;
        carry      = 1'b0;
        digit_sum  = '0;
        for (int unsigned l = 0; l < LANES; l++) begin
            digit_sum = {1'b0, bcd[l][0]} + 5'(LANES);
            if (digit_sum >= 5'd10) begin
                bcd_next[l][0] = 4'(digit_sum - 5'd10);
                carry          = 1'b1;
            end else begin
                bcd_next[l][0] = digit_sum[3:0];
                carry          = 1'b0;
            end
            for (int unsigned i = 1; i < DIGITS; i++) begin
                if (carry) begin
                    if (bcd[l][i] == 4'd9) begin
                        bcd_next[l][i] = '0;
                    end else begin
                        bcd_next[l][i] = bcd[l][i] + 4'd1;
                        carry          = 1'b0;
                    end
                end
            end
            lane_carry[l] = carry;
        end
    end

    assign any_carry = |lane_carry;

    always_comb begin
        enabled_digits = '0;
        digit_count    = '0;
        for (int unsigned l = 0; l < LANES; l++) begin
            digit_count = W'(1);
            for (int unsigned i = 0; i < DIGITS; i++) begin
                if (bcd[l][i] != 4'd0) digit_count = W'(i + 1);
            end
            enabled_digits[l*W +: W] = digit_count;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= LOAD;
            bcd   <= bcd_init;
        end else if (clear) begin
            state <= LOAD;
            bcd   <= bcd_init;
        end else begin
            case (state)
                LOAD: state <= RUN;
                RUN: begin
                    if (ready) begin
                        if (any_carry) state <= DONE;
                        else           bcd   <= bcd_next;
                    end
                end
                DONE:    state <= DONE;
                default: state <= LOAD;
            endcase
        end
    end

    assign valid    = (state == RUN);
    assign overflow = (state == DONE);

endmodule

// File: tb/tb_ascii_lane_counter.sv
// Directed bench for ascii_lane_counter: three configurations (4x3 from 1, 2x3 from 1, 3x1 from 98).
module tb_ascii_lane_counter;

    logic clk;
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    logic        rst_a, clear_a, ready_a, valid_a, ovf_a;
    logic [95:0] ascii_a;
    logic [8:0]  en_a;

    logic        rst_b, clear_b, ready_b, valid_b, ovf_b;
    logic [47:0] ascii_b;
    logic [5:0]  en_b;

    logic        rst_c, clear_c, ready_c, valid_c, ovf_c;
    logic [23:0] ascii_c;
    logic [1:0]  en_c;

    ascii_lane_counter #(.DIGITS(4), .LANES(3), .START(64'd1)) dut_a (
        .clk(clk), .reset(rst_a), .clear(clear_a), .ready(ready_a), .valid(valid_a),
        .ascii_digits(ascii_a), .enabled_digits(en_a), .overflow(ovf_a));

    ascii_lane_counter #(.DIGITS(2), .LANES(3), .START(64'd1)) dut_b (
        .clk(clk), .reset(rst_b), .clear(clear_b), .ready(ready_b), .valid(valid_b),
        .ascii_digits(ascii_b), .enabled_digits(en_b), .overflow(ovf_b));

    ascii_lane_counter #(.DIGITS(3), .LANES(1), .START(64'd98)) dut_c (
        .clk(clk), .reset(rst_c), .clear(clear_c), .ready(ready_c), .valid(valid_c),
        .ascii_digits(ascii_c), .enabled_digits(en_c), .overflow(ovf_c));

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic ready;
        logic clear;
        logic valid;
        logic ovf;
        int   lane[3];
        int   en;
    } vec_t;

    vec_t vecs[$];

    function automatic logic [127:0] to_ascii(input int unsigned v, input int unsigned nd);
        logic [127:0] r;
        int unsigned  x;
        r = '0;
        x = v;
        for (int unsigned i = 0; i < nd; i++) begin
            r[8*i +: 8] = 8'h30 + 8'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    function automatic int ndig(input int v);
        int n;
        int x;
        n = 1;
        x = v;
        while (x >= 10) begin
            x = x / 10;
            n++;
        end
        return n;
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic check_a(input string tag, input logic v, input logic o,
                           input int l0, input int l1, input int l2, input int e);
        int lv[3];
        lv = '{l0, l1, l2};
        check({tag, "_valid"}, 128'(valid_a), 128'(v));
        check({tag, "_overflow"}, 128'(ovf_a), 128'(o));
        for (int k = 0; k < 3; k++) begin
            check($sformatf("%s_lane%0d", tag, k), 128'(ascii_a[k*32 +: 32]), to_ascii(lv[k], 4));
            check($sformatf("%s_en%0d", tag, k), 128'(en_a[k*3 +: 3]), 128'(e));
        end
    endtask

    task automatic check_b(input string tag, input logic v, input logic o, input int l0);
        check({tag, "_valid"}, 128'(valid_b), 128'(v));
        check({tag, "_overflow"}, 128'(ovf_b), 128'(o));
        for (int k = 0; k < 3; k++) begin
            check($sformatf("%s_lane%0d", tag, k), 128'(ascii_b[k*16 +: 16]), to_ascii(l0 + k, 2));
            check($sformatf("%s_en%0d", tag, k), 128'(en_b[k*2 +: 2]), 128'(ndig(l0 + k)));
        end
    endtask

    task automatic check_c(input string tag, input logic v, input int l0, input int e);
        check({tag, "_valid"}, 128'(valid_c), 128'(v));
        check({tag, "_overflow"}, 128'(ovf_c), 128'(1'b0));
        check({tag, "_lane0"}, 128'(ascii_c), to_ascii(l0, 3));
        check({tag, "_en0"}, 128'(en_c), 128'(e));
    endtask

    task automatic add(input logic r, input logic c, input logic v, input logic o,
                       input int l0, input int l1, input int l2, input int e);
        vec_t t;
        t.ready = r;
        t.clear = c;
        t.valid = v;
        t.ovf   = o;
        t.lane  = '{l0, l1, l2};
        t.en    = e;
        vecs.push_back(t);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at time limit, required finish");
        $fatal(1, "timeout");
    end

    initial begin
        // Post-release cycle-by-cycle expectations for the 4-digit, 3-lane instance.
        add(0, 0, 1, 0, 1, 2, 3, 1);
        for (int k = 0; k < 10; k++) add(0, 0, 1, 0, 1, 2, 3, 1);
        add(1, 0, 1, 0, 4, 5, 6, 1);
        add(1, 0, 1, 0, 7, 8, 9, 1);
        add(1, 0, 1, 0, 10, 11, 12, 2);
        add(1, 0, 1, 0, 13, 14, 15, 2);
        add(1, 1, 0, 0, 1, 2, 3, 1);
        add(1, 0, 1, 0, 1, 2, 3, 1);
        add(1, 0, 1, 0, 4, 5, 6, 1);
        add(0, 0, 1, 0, 4, 5, 6, 1);

        {rst_a, clear_a, ready_a} = 3'b000;
        {rst_b, clear_b, ready_b} = 3'b000;
        {rst_c, clear_c, ready_c} = 3'b000;
        #1;
        rst_a = 1'b1;
        rst_b = 1'b1;
        rst_c = 1'b1;
        #1;
        check_a("reset_a", 0, 0, 1, 2, 3, 1);
        check_b("reset_b", 0, 0, 1);
        check_c("reset_c", 0, 98, 2);

        @(negedge clk);
        rst_a = 1'b0;
        rst_b = 1'b0;
        rst_c = 1'b0;
        for (int k = 0; k < vecs.size(); k++) begin
            ready_a = vecs[k].ready;
            clear_a = vecs[k].clear;
            @(posedge clk);
            #1;
            check_a($sformatf("vec%0d", k), vecs[k].valid, vecs[k].ovf,
                    vecs[k].lane[0], vecs[k].lane[1], vecs[k].lane[2], vecs[k].en);
            @(negedge clk);
        end

        // Asynchronous reset between edges while in RUN.
        #2 rst_a = 1'b1;
        #1 check_a("midrun_reset", 0, 0, 1, 2, 3, 1);
        @(negedge clk);
        rst_a = 1'b0;
        @(posedge clk);
        #1 check_a("after_reset", 1, 0, 1, 2, 3, 1);

        // Overflow sweep on the 2-digit instance: 32 handshakes reach 97/98/99.
        check_b("b_idle", 1, 0, 1);
        @(negedge clk);
        ready_b = 1'b1;
        for (int k = 1; k <= 32; k++) begin
            @(posedge clk);
            #1 check_b($sformatf("b_step%0d", k), 1, 0, 1 + 3 * k);
        end
        @(posedge clk);
        #1 check_b("b_overflow", 0, 1, 97);
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1 check_b($sformatf("b_done%0d", k), 0, 1, 97);
        end
        @(negedge clk);
        clear_b = 1'b1;
        @(posedge clk);
        #1 check_b("b_clear", 0, 0, 1);
        @(negedge clk);
        clear_b = 1'b0;
        @(posedge clk);
        #1 check_b("b_resume", 1, 0, 1);
        @(posedge clk);
        #1 check_b("b_advance", 1, 0, 4);
        @(negedge clk);
        ready_b = 1'b0;

        // Single-lane instance crossing into a third significant digit.
        check_c("c_idle", 1, 98, 2);
        ready_c = 1'b1;
        @(posedge clk);
        #1 check_c("c_099", 1, 99, 2);
        @(posedge clk);
        #1 check_c("c_100", 1, 100, 3);
        @(negedge clk);
        ready_c = 1'b0;
        @(posedge clk);
        #1 check_c("c_hold", 1, 100, 3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
